arb_rr8: RTL and testbench

Eight-requester round-robin arbiter that shares a single downstream resource selected through a one-hot 8-line select bus. The arbiter picks one requester, holds the grant until the owner signals completion, then rotates priority past the previous owner. It sits between eight client ports and the shared resource. It drives both the 3-bit owner index and the one-hot select.

---
 rtl/arb_rr8.sv | 145 ++++++++++++++
 tb/tb_arb_rr8.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_rr8.sv
//------------------------------------------------------------------------------
// arb_rr8 : eight-requester round-robin arbiter with one-hot grant and index.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arb_rr8 #(
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] grant,
   output logic [2:0] grant_idx,
   output logic       grant_valid,
   output logic       timeout
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] grant_q, grant_d;
   logic       valid_q, valid_d;

   logic       w_found;
   logic [2:0] w_winner;
   logic [2:0] w_cand;
   logic       w_expire;
   logic       w_release;

   if (MAX_HOLD == 0 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("arb_rr8: MAX_HOLD must be in 1..255");
   end

   // Descending scan so the requester closest to ptr (offset 0) wins last.
   always_comb begin
      w_found  = 1'b0;
      w_winner = ptr_q;
      w_cand   = ptr_q;
      for (int i = 7; i >= 0; i--) begin
         w_cand = ptr_q + 3'(i);
         if (req[w_cand]) begin
            w_winner = w_cand;
            w_found  = 1'b1;
         end
      end
   end

   assign w_release = (state_q == BUSY) && (done || w_expire);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      grant_d = grant_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (w_found) begin
               idx_d   = w_winner;
               grant_d = 8'd1 << w_winner;
               valid_d = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (w_release) begin
               grant_d = 8'h00;
               valid_d = 1'b0;
               ptr_d   = idx_q + 3'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         idx_q   <= 3'd0;
         grant_q <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = idx_q;
   assign grant_valid = valid_q;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] hold_q, hold_d;
   logic       timeout_q, timeout_d;

   // hold_q counts completed BUSY cycles; it is zero during the first one.
   assign w_expire = (state_q == BUSY) && (hold_q == C_HOLD_LAST);

   always_comb begin
      hold_d    = hold_q;
      timeout_d = 1'b0;
      if (state_q == IDLE) begin
         hold_d = 8'd0;
      end else if (!w_release) begin
         hold_d = hold_q + 8'd1;
      end
      if (w_expire && !done) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign w_expire = 1'b0;
   assign timeout  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arb_rr8.sv
//------------------------------------------------------------------------------
// tb_arb_rr8 : scoreboard bench for arb_rr8 (expected {grant,idx,valid,timeout}).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_arb_rr8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [12:0] v;
      string       n;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   arb_rr8 #(.MAX_HOLD(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [7:0] g, input logic [2:0] i,
                               input logic vl, input logic t, input string n);
      exp_t x;
      x.v = {g, i, vl, t};
      x.n = n;
      return x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 8'h00; done = 1'b0;
      tick(); tick();
      sb.push_back(mk(8'h00, 3'd0, 1'b0, 1'b0, "reset_state"));
      e = sb.pop_front(); checks++;
      if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
         errors++; $display("FAIL %s: got %h expected %h", e.n, {grant, grant_idx, grant_valid, timeout}, e.v);
      end
      rst_n = 1'b1; req = 8'h08;
      sb.push_back(mk(8'h08, 3'd3, 1'b1, 1'b0, "reset_first_grant"));
      tick();
      e = sb.pop_front(); checks++;
      if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
         errors++; $display("FAIL %s: got %h expected %h", e.n, {grant, grant_idx, grant_valid, timeout}, e.v);
      end
      req = 8'h00;
      tick();
      #2 rst_n = 1'b0;
      sb.push_back(mk(8'h00, 3'd0, 1'b0, 1'b0, "async_reset"));
      #1;
      e = sb.pop_front(); checks++;
      if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
         errors++; $display("FAIL %s: got %h expected %h", e.n, {grant, grant_idx, grant_valid, timeout}, e.v);
      end
      tick();
      rst_n = 1'b1; req = 8'h01;
      sb.push_back(mk(8'h01, 3'd0, 1'b1, 1'b0, "post_reset_grant"));
      tick();
      e = sb.pop_front(); checks++;
      if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
         errors++; $display("FAIL %s: got %h expected %h", e.n, {grant, grant_idx, grant_valid, timeout}, e.v);
      end
      done = 1'b1; req = 8'h00;
      sb.push_back(mk(8'h00, 3'd0, 1'b0, 1'b0, "post_reset_release"));
      tick();
      e = sb.pop_front(); checks++;
      if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
         errors++; $display("FAIL %s: got %h expected %h", e.n, {grant, grant_idx, grant_valid, timeout}, e.v);
      end
      done = 1'b0;
   endtask

   task automatic test_rotation();
      logic [2:0] k3;
      rst_n = 1'b0; #1 rst_n = 1'b1;
      req = 8'hFF; done = 1'b0;
      for (int k = 0; k < 9; k++) begin
         k3 = 3'(k % 8);
         sb.push_back(mk(8'd1 << k3, k3, 1'b1, 1'b0, "rotation_grant"));
         tick();
         e = sb.pop_front(); checks++;
         if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
            errors++; $display("FAIL %s[%0d]: got %h expected %h", e.n, k, {grant, grant_idx, grant_valid, timeout}, e.v);
         end
         done = 1'b1;
         sb.push_back(mk(8'h00, k3, 1'b0, 1'b0, "rotation_idle"));
         tick();
         e = sb.pop_front(); checks++;
         if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
            errors++; $display("FAIL %s[%0d]: got %h expected %h", e.n, k, {grant, grant_idx, grant_valid, timeout}, e.v);
         end
         done = 1'b0;
      end
      req = 8'h00;
      tick();
   endtask

   // Entry: ptr=1 (last owner was 0).
   task automatic test_wrap();
      req = 8'h20;
      sb.push_back(mk(8'h20, 3'd5, 1'b1, 1'b0, "wrap_grant5"));
      sb.push_back(mk(8'h00, 3'd5, 1'b0, 1'b0, "wrap_release5"));
      sb.push_back(mk(8'h01, 3'd0, 1'b1, 1'b0, "wrap_grant0"));
      sb.push_back(mk(8'h00, 3'd0, 1'b0, 1'b0, "wrap_release0"));
      for (int s = 0; s < 4; s++) begin
         tick();
         e = sb.pop_front(); checks++;
         if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
            errors++; $display("FAIL %s: got %h expected %h", e.n, {grant, grant_idx, grant_valid, timeout}, e.v);
         end
         case (s)
            0: begin done = 1'b1; req = 8'h00; end
            1: begin done = 1'b0; req = 8'b0010_0001; end
            2: begin done = 1'b1; req = 8'h00; end
            default: done = 1'b0;
         endcase
      end
   endtask

   // Entry: ptr=1.
   task automatic test_hold();
      int n;
`ifdef ARB_TIMEOUT_EN
      n = 2;
`else
      n = 20;
`endif
      req = 8'h04;
      sb.push_back(mk(8'h04, 3'd2, 1'b1, 1'b0, "hold_grant"));
      tick();
      e = sb.pop_front(); checks++;
      if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
         errors++; $display("FAIL %s: got %h expected %h", e.n, {grant, grant_idx, grant_valid, timeout}, e.v);
      end
      for (int c = 0; c < n; c++) begin
         req = (c % 2 == 0) ? 8'h00 : 8'hFB;
         sb.push_back(mk(8'h04, 3'd2, 1'b1, 1'b0, "hold_stay"));
         tick();
         e = sb.pop_front(); checks++;
         if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
            errors++; $display("FAIL %s[%0d]: got %h expected %h", e.n, c, {grant, grant_idx, grant_valid, timeout}, e.v);
         end
      end
      req = 8'h00; done = 1'b1;
      sb.push_back(mk(8'h00, 3'd2, 1'b0, 1'b0, "hold_release"));
      tick();
      e = sb.pop_front(); checks++;
      if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
         errors++; $display("FAIL %s: got %h expected %h", e.n, {grant, grant_idx, grant_valid, timeout}, e.v);
      end
      done = 1'b0;
   endtask

   // Entry: ptr=3. Also checks that done in IDLE changes nothing.
   task automatic test_simultaneous();
      req = 8'h08;
      sb.push_back(mk(8'h08, 3'd3, 1'b1, 1'b0, "simul_grant3"));
      sb.push_back(mk(8'h00, 3'd3, 1'b0, 1'b0, "simul_idle"));
      sb.push_back(mk(8'h10, 3'd4, 1'b1, 1'b0, "simul_grant4"));
      sb.push_back(mk(8'h00, 3'd4, 1'b0, 1'b0, "simul_release4"));
      sb.push_back(mk(8'h00, 3'd4, 1'b0, 1'b0, "done_in_idle"));
      for (int s = 0; s < 5; s++) begin
         tick();
         e = sb.pop_front(); checks++;
         if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
            errors++; $display("FAIL %s: got %h expected %h", e.n, {grant, grant_idx, grant_valid, timeout}, e.v);
         end
         case (s)
            0: begin done = 1'b1; req = 8'h18; end
            1: done = 1'b0;
            2: begin done = 1'b1; req = 8'h00; end
            default: done = 1'b1;
         endcase
      end
      done = 1'b0;
   endtask

   // Entry: ptr=5, idle.
   task automatic test_timeout();
      req = 8'h08;
`ifdef ARB_TIMEOUT_EN
      for (int c = 0; c < 4; c++)
         sb.push_back(mk(8'h08, 3'd3, 1'b1, 1'b0, "to_high"));
      sb.push_back(mk(8'h00, 3'd3, 1'b0, 1'b1, "to_pulse"));
      for (int c = 0; c < 4; c++)
         sb.push_back(mk(8'h08, 3'd3, 1'b1, 1'b0, "to_regrant"));
      sb.push_back(mk(8'h00, 3'd3, 1'b0, 1'b0, "to_done_at_limit"));
      for (int s = 0; s < 10; s++) begin
         if (s == 9) begin done = 1'b1; req = 8'h00; end
         tick();
         e = sb.pop_front(); checks++;
         if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
            errors++; $display("FAIL %s[%0d]: got %h expected %h", e.n, s, {grant, grant_idx, grant_valid, timeout}, e.v);
         end
      end
`else
      for (int c = 0; c < 120; c++) begin
         sb.push_back(mk(8'h08, 3'd3, 1'b1, 1'b0, "no_to_hold"));
         tick();
         e = sb.pop_front(); checks++;
         if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
            errors++; $display("FAIL %s[%0d]: got %h expected %h", e.n, c, {grant, grant_idx, grant_valid, timeout}, e.v);
         end
      end
      done = 1'b1; req = 8'h00;
      sb.push_back(mk(8'h00, 3'd3, 1'b0, 1'b0, "no_to_release"));
      tick();
      e = sb.pop_front(); checks++;
      if ({grant, grant_idx, grant_valid, timeout} !== e.v) begin
         errors++; $display("FAIL %s: got %h expected %h", e.n, {grant, grant_idx, grant_valid, timeout}, e.v);
      end
`endif
      done = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'h00;
      done  = 1'b0;
      test_reset();
      test_rotation();
      test_wrap();
      test_hold();
      test_simultaneous();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
